// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB instruction sequencer
// Strobes are decoded from the current state and latched opcode; only PC_LOAD sees an input (BR_TAKEN).

package multicycle_control_pkg;
  localparam logic [4:0] kADD = 5'd0;
  localparam logic [4:0] kSHF = 5'd1;
  localparam logic [4:0] kMOV = 5'd2;
  localparam logic [4:0] kFIL = 5'd3;
  localparam logic [4:0] kCMP = 5'd4;
  localparam logic [4:0] kAND = 5'd5;
  localparam logic [4:0] kNEG = 5'd6;
  localparam logic [4:0] kBRH = 5'd7;
endpackage

module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int DW          = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNTW        = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            halt_req_i,
  input  logic [OPW-1:0]  opcode_i,
  input  logic [DW-1:0]   dest_sel_i,
  input  logic            br_taken_i,
  input  logic            mem_ready_i,
  output logic            ir_load_o,
  output logic            pc_inc_o,
  output logic            pc_load_o,
  output logic            mem_wr_o,
  output logic            reg_wr_o,
  output logic            flag_wr_o,
  output logic [DW-1:0]   mem_dest_o,
  output logic [DW-1:0]   reg_dest_o,
  output logic            busy_o,
  output logic            illegal_o,
  output logic            timeout_o,
  output logic [2:0]      state_o,
  output logic [CNTW-1:0] instr_cnt_o
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6,
    S_RSVD   = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [DW-1:0]   dest_q, dest_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic            halt_q, halt_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            busy, retire, halt_pend;

  function automatic logic is_legal(input logic [OPW-1:0] op);
    return (op == OPW'(kADD)) || (op == OPW'(kSHF)) || (op == OPW'(kMOV)) ||
           (op == OPW'(kFIL)) || (op == OPW'(kCMP)) || (op == OPW'(kAND)) ||
           (op == OPW'(kNEG)) || (op == OPW'(kBRH));
  endfunction

  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                     (state_q == S_MEM)   || (state_q == S_WB);
  // A halt request in the retiring cycle itself still stops after that instruction.
  assign halt_pend = halt_q | (busy & halt_req_i);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dest_d    = dest_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d   = opcode_i;
        dest_d = dest_sel_i;
        if (is_legal(opcode_i)) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_ERR;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (op_q == OPW'(kBRH)) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Ready is checked first so it wins against the final timeout cycle.
        if (mem_ready_i) begin
          retire = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
          if (wait_q == WCW'(MEM_TIMEOUT - 1)) begin
            state_d   = S_ERR;
            timeout_d = 1'b1;
          end
        end
      end
      S_WB: retire = 1'b1;
      S_ERR: begin
        if (start_i) begin
          state_d   = S_IDLE;
          illegal_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: begin
        if (start_i) state_d = S_FETCH;
      end
    endcase
    if (retire) begin
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNTW'(1);
      state_d = halt_pend ? S_IDLE : S_FETCH;
    end
    halt_d = (state_d == S_IDLE) ? 1'b0 : halt_pend;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      dest_q    <= '0;
      wait_q    <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      wait_q    <= wait_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    ir_load_o  = 1'b0;
    pc_inc_o   = 1'b0;
    pc_load_o  = 1'b0;
    mem_wr_o   = 1'b0;
    reg_wr_o   = 1'b0;
    flag_wr_o  = 1'b0;
    mem_dest_o = '0;
    reg_dest_o = '0;
    case (state_q)
      S_FETCH: begin
        ir_load_o = 1'b1;
        pc_inc_o  = 1'b1;
      end
      S_EXEC: pc_load_o = (op_q == OPW'(kBRH)) & br_taken_i;
      S_MEM: begin
        mem_wr_o   = 1'b1;
        mem_dest_o = dest_q;
      end
      S_WB: begin
        if (op_q == OPW'(kCMP)) begin
          flag_wr_o = 1'b1;
        end else begin
          reg_wr_o   = 1'b1;
          reg_dest_o = dest_q;
        end
      end
      default: ;
    endcase
  end

  assign busy_o      = busy;
  assign illegal_o   = illegal_q;
  assign timeout_o   = timeout_q;
  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - vector-table and directed bench for multicycle_control
// Vectors are produced per instruction from an instruction-level model, then replayed cycle by cycle.

module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int CNTW = 8;
  localparam int MTO  = 15;
  localparam logic [5:0] SB_FETCH = 6'b110000;
  localparam logic [5:0] SB_PCLD  = 6'b001000;
  localparam logic [5:0] SB_MEMWR = 6'b000100;
  localparam logic [5:0] SB_REGWR = 6'b000010;
  localparam logic [5:0] SB_FLGWR = 6'b000001;

  logic clk = 1'b0;
  logic rst_n, start, halt, br, rdy;
  logic [4:0] op;
  logic [2:0] dest;
  logic ir_load, pc_inc, pc_load, mem_wr, reg_wr, flag_wr, busy, illegal, timeout;
  logic [2:0] mem_dest, reg_dest, state;
  logic [CNTW-1:0] instr_cnt;
  logic [25:0] act;

  multicycle_control #(.OPW(5), .DW(3), .MEM_TIMEOUT(MTO), .CNTW(CNTW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .halt_req_i(halt),
    .opcode_i(op), .dest_sel_i(dest), .br_taken_i(br), .mem_ready_i(rdy),
    .ir_load_o(ir_load), .pc_inc_o(pc_inc), .pc_load_o(pc_load), .mem_wr_o(mem_wr),
    .reg_wr_o(reg_wr), .flag_wr_o(flag_wr), .mem_dest_o(mem_dest), .reg_dest_o(reg_dest),
    .busy_o(busy), .illegal_o(illegal), .timeout_o(timeout), .state_o(state),
    .instr_cnt_o(instr_cnt)
  );

  always #5 clk = ~clk;

  assign act = {ir_load, pc_inc, pc_load, mem_wr, reg_wr, flag_wr, mem_dest, reg_dest,
                busy, illegal, timeout, state, instr_cnt};

  typedef struct {
    bit rst_n, start, halt;
    logic [4:0] op;
    logic [2:0] dest;
    bit br, rdy, chk;
    logic [25:0] exp;
    int tag;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0, n_bad = 0;
  int m_cnt = 0, cur_tag = 0;
  bit m_ill = 0, m_tmo = 0, m_halt = 0, rnd = 0;
  logic [4:0] legal_ops [8] = '{kADD, kSHF, kMOV, kFIL, kCMP, kAND, kNEG, kBRH};

  function automatic bit dc();
    return rnd ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction
  function automatic logic [4:0] jop();
    return rnd ? 5'($urandom) : 5'd0;
  endfunction
  function automatic logic [2:0] jdst();
    return rnd ? 3'($urandom) : 3'd0;
  endfunction

  function automatic void emit(bit st_in, bit hl, logic [4:0] o, logic [2:0] d, bit b, bit r,
                               int st, logic [5:0] strb, logic [2:0] md, logic [2:0] rd);
    vec_t v;
    bit bsy;
    bsy = (st >= 1 && st <= 5);
    v.rst_n = 1'b1; v.start = st_in; v.halt = hl; v.op = o; v.dest = d; v.br = b; v.rdy = r;
    v.chk = 1'b1; v.tag = cur_tag;
    v.exp = {strb, md, rd, bsy, m_ill, m_tmo, 3'(st), 8'(m_cnt)};
    vecs.push_back(v);
    if (bsy && hl) m_halt = 1'b1;
  endfunction

  function automatic void rst_cycle(bit chk);
    vec_t v;
    m_cnt = 0; m_ill = 0; m_tmo = 0; m_halt = 0;
    v.rst_n = 1'b0; v.start = 1'($urandom_range(0, 1)); v.halt = 1'($urandom_range(0, 1));
    v.op = 5'($urandom); v.dest = 3'($urandom); v.br = 1'($urandom_range(0, 1));
    v.rdy = 1'($urandom_range(0, 1)); v.chk = chk; v.tag = cur_tag; v.exp = '0;
    vecs.push_back(v);
  endfunction

  function automatic void idle(bit st_in);
    emit(st_in, dc(), jop(), jdst(), dc(), dc(), 0, 6'b0, 3'd0, 3'd0);
  endfunction

  function automatic void err(int n);
    for (int i = 0; i < n; i++) emit(1'b0, dc(), jop(), jdst(), dc(), dc(), 6, 6'b0, 3'd0, 3'd0);
    emit(1'b1, dc(), jop(), jdst(), dc(), dc(), 6, 6'b0, 3'd0, 3'd0);
    m_ill = 0; m_tmo = 0; m_halt = 0;
  endfunction

  // Returns 0: next is FETCH, 1: halted to IDLE, 2: in ERR, 3: stopped before cycle 'abort'.
  function automatic int instr(logic [4:0] o, logic [2:0] d, bit b, int delay, int hp, int abort);
    int ph;
    bit brh, cmp, legal;
    ph = 0;
    brh = (o == kBRH);
    cmp = (o == kCMP);
    legal = o inside {kADD, kSHF, kMOV, kFIL, kCMP, kAND, kNEG, kBRH};
    if (abort == ph) return 3;
    emit(dc(), hp == ph, jop(), jdst(), dc(), dc(), 1, SB_FETCH, 3'd0, 3'd0); ph++;
    if (abort == ph) return 3;
    emit(dc(), hp == ph, o, d, dc(), dc(), 2, 6'b0, 3'd0, 3'd0); ph++;
    if (!legal) begin m_ill = 1'b1; return 2; end
    if (abort == ph) return 3;
    emit(dc(), hp == ph, jop(), jdst(), b, dc(), 3, (brh && b) ? SB_PCLD : 6'b0, 3'd0, 3'd0); ph++;
    if (brh) begin
      for (int k = 0; k < MTO; k++) begin
        if (abort == ph) return 3;
        emit(dc(), hp == ph, jop(), jdst(), dc(), k == delay, 4, SB_MEMWR, d, 3'd0); ph++;
        if (k == delay) break;
        if (k == MTO - 1) begin m_tmo = 1'b1; return 2; end
      end
    end else begin
      if (abort == ph) return 3;
      emit(dc(), hp == ph, jop(), jdst(), dc(), dc(), 5, cmp ? SB_FLGWR : SB_REGWR, 3'd0,
           cmp ? 3'd0 : d);
    end
    if (m_cnt < 255) m_cnt++;
    if (m_halt) begin m_halt = 1'b0; return 1; end
    return 0;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chk(string nm, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    int r, n, wr;
    logic [4:0] o;
    cur_tag = 1; rnd = 0; rst_cycle(0); rst_cycle(1); rnd = 1; idle(0); idle(0);
    cur_tag = 2; idle(1); r = instr(kADD, 3'd5, 1'b0, 0, -1, -1); r = instr(kMOV, 3'd3, 1'b1, 0, 0, -1); idle(0);
    cur_tag = 3; idle(1); r = instr(kBRH, 3'd2, 1'b1, 3, -1, -1); r = instr(kNEG, 3'd7, 1'b0, 0, 2, -1); idle(0);
    cur_tag = 4; idle(1); r = instr(kBRH, 3'd6, 1'b0, 99, -1, -1); err(2); idle(0);
    cur_tag = 5; idle(1); r = instr(5'h1F, 3'd4, 1'b0, 0, -1, -1); err(1); idle(0);
    cur_tag = 6; idle(1); r = instr(kBRH, 3'd4, 1'b0, MTO - 1, -1, -1); r = instr(kBRH, 3'd1, 1'b1, 0, 0, -1); idle(0);
    cur_tag = 7; idle(1); r = instr(kAND, 3'd2, 1'b0, 0, -1, -1); r = instr(kBRH, 3'd3, 1'b1, 99, -1, 5);
    rst_cycle(0); idle(0);
    cur_tag = 8;
    for (int p = 0; p < 300; p++) begin
      repeat ($urandom_range(0, 2)) idle(0);
      idle(1);
      n = 0;
      do begin
        o = ($urandom_range(0, 7) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 7)];
        r = instr(o, 3'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(12, 16) : $urandom_range(0, 4),
                  (n >= 6) ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1),
                  ($urandom_range(0, 29) == 0) ? $urandom_range(0, 6) : -1);
        n++;
      end while (r == 0);
      if (r == 2) err($urandom_range(0, 2));
      if (r == 3) begin rst_cycle(0); if ($urandom_range(0, 1) == 1) rst_cycle(1); end
    end
    cur_tag = 9; idle(1);
    while (m_cnt < 255) r = instr(legal_ops[$urandom_range(0, 6)], 3'($urandom), 1'b0, 0, -1, -1);
    r = instr(kADD, 3'd1, 1'b0, 0, -1, -1);
    r = instr(kCMP, 3'd5, 1'b0, 0, 1, -1); idle(0); idle(0);
    cur_tag = 10; rst_cycle(0); idle(0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; start = vecs[i].start; halt = vecs[i].halt; op = vecs[i].op;
      dest = vecs[i].dest; br = vecs[i].br; rdy = vecs[i].rdy;
      #2;
      if (vecs[i].chk) begin
        n_vec++;
        if (act !== vecs[i].exp) begin
          n_bad++;
          $display("FAIL vec%0d tag%0d: got %h, expected %h", i, vecs[i].tag, act, vecs[i].exp);
        end
      end
      @(posedge clk); #1;
    end

    // Branch with ready after three wait cycles, then a branch that never gets ready.
    rst_n = 0; start = 0; halt = 0; op = kBRH; dest = 3'd2; br = 0; rdy = 0; cyc();
    rst_n = 1; cyc();
    start = 1; cyc();
    start = 0; cyc();
    cyc();
    br = 1; #1; chk("pc_load_in_exec", pc_load, 1); cyc(); br = 0;
    wr = 0;
    for (int k = 0; k < 20 && state == 3'd4; k++) begin
      rdy = (k == 3); #1; wr += int'(mem_wr); cyc();
    end
    rdy = 0;
    chk("mem_wr_cycles", wr, 4);
    chk("cnt_after_branch", int'(instr_cnt), 1);
    chk("state_after_retire", int'(state), 1);
    dest = 3'd6; cyc(); cyc(); cyc();
    n = 0;
    for (int k = 0; k < 40 && state == 3'd4; k++) begin n += int'(mem_wr); cyc(); end
    chk("timeout_wait_cycles", n, MTO);
    chk("state_err", int'(state), 6);
    chk("timeout_flag", int'(timeout), 1);
    chk("cnt_preserved", int'(instr_cnt), 1);
    start = 1; cyc(); start = 0;
    chk("err_to_idle", int'(state), 0);
    chk("timeout_cleared", int'(timeout), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPW, default 5, opcode width; opcode mnemonics and encodings come from the definitions package (kADD, kSHF, kMOV, kFIL, kCMP, kAND, kNEG, kBRH).
REQ-002 Parameter DW, default 3, destination-select width.
REQ-003 Parameter MEM_TIMEOUT, default 15, maximum MEM wait cycles before error.
REQ-004 Parameter CNTW, default 16, retired-instruction counter width.
REQ-005 The block SHALL use one clock, and its reset SHALL be synchronous and active-low.
REQ-006 CLK  in  1  clock; all state updates on the rising edge.
REQ-007 RST_N  in  1  synchronous active-low reset.
REQ-008 START  in  1  begin execution from IDLE; clear error from ERR.
REQ-009 HALT_REQ  in  1  stop after the current instruction retires.
REQ-010 OPCODE  in  OPW  instruction opcode, sampled in DECODE.
REQ-011 DEST_SEL  in  DW  destination select, sampled in DECODE.
REQ-012 BR_TAKEN  in  1  branch condition, sampled in EXEC.
REQ-013 MEM_READY  in  1  memory write-acknowledge handshake.
REQ-014 IR_LOAD, PC_INC, PC_LOAD, MEM_WR, REG_WR, FLAG_WR  out  1 each  control strobes.
REQ-015 MEM_DEST, REG_DEST  out  DW each  destination selects.
REQ-016 BUSY  out  1  high in every state except IDLE and ERR.
REQ-017 ILLEGAL, TIMEOUT  out  1 each  sticky error flags.
REQ-018 STATE  out  3  current state encoding.
REQ-019 INSTR_CNT  out  CNTW  retired-instruction count.

Function
REQ-020 State encodings SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6; code 7 SHALL behave as IDLE.
REQ-021 Strobes SHALL be Moore outputs decoded from the state and the latched opcode; they are never registered one cycle late.
REQ-022 IDLE: START=1 -> FETCH; otherwise remain in IDLE.
REQ-023 FETCH: IR_LOAD=1 and PC_INC=1 for exactly one cycle -> DECODE.
REQ-024 DECODE: OPCODE and DEST_SEL are latched; an unlisted opcode -> ERR and sets ILLEGAL, otherwise -> EXEC.
REQ-025 EXEC (one cycle): kBRH -> MEM, with PC_LOAD=1 in EXEC iff BR_TAKEN=1; every other opcode -> WB.
REQ-026 MEM: MEM_WR=1 and MEM_DEST=latched DEST_SEL held each cycle until MEM_READY=1 is sampled; that cycle retires the instruction.
REQ-027 MEM wait counter: cleared on MEM entry and incremented on each MEM cycle with MEM_READY=0; on reaching MEM_TIMEOUT -> ERR and sets TIMEOUT.
REQ-028 If MEM_READY=1 arrives in the same cycle the counter reaches MEM_TIMEOUT, the ready SHALL win (retire, no timeout).
REQ-029 WB (one cycle): kCMP -> FLAG_WR=1 and REG_WR=0; kADD/kSHF/kMOV/kFIL/kAND/kNEG -> REG_WR=1 and REG_DEST=latched DEST_SEL; the instruction retires.
REQ-030 MEM_DEST and REG_DEST SHALL be 0 whenever their strobe is low.
REQ-031 On retirement, INSTR_CNT increments by 1 and saturates at all-ones; the next state is IDLE if a halt is pending, else FETCH.
REQ-032 HALT_REQ=1 in any BUSY cycle sets halt-pending; halt-pending is cleared on entry to IDLE; HALT_REQ in IDLE is ignored.
REQ-033 START while BUSY=1 is ignored.
REQ-034 ERR: all strobes are 0; START=1 -> IDLE and clears ILLEGAL and TIMEOUT; INSTR_CNT is preserved.
REQ-035 The block has no combinational path from any input to any strobe, except BR_TAKEN -> PC_LOAD in EXEC and MEM_READY having no strobe effect.

Reset
REQ-036 RST_N=0 at a clock edge -> STATE=IDLE; all strobes, MEM_DEST, REG_DEST, BUSY, ILLEGAL, TIMEOUT=0; INSTR_CNT=0; wait counter=0; halt-pending=0.
REQ-037 Reset asserted mid-instruction (including mid-MEM wait) SHALL abort the instruction without retiring it, and no strobe is asserted in the cycle after the reset edge.

Verification
REQ-038 kADD with DEST_SEL=5, START pulse -> IR_LOAD at cycle 1, REG_WR=1 with REG_DEST=5 at cycle 4, INSTR_CNT=1, then FETCH.
REQ-039 kBRH with BR_TAKEN=1 and MEM_READY delayed 3 cycles -> PC_LOAD in EXEC, MEM_WR held 4 cycles, retire, INSTR_CNT+1.
REQ-040 kBRH with MEM_READY=0 throughout -> ERR after 15 wait cycles, TIMEOUT=1; then START -> IDLE with TIMEOUT=0.
REQ-041 Illegal opcode -> ERR from DECODE, ILLEGAL=1, no REG_WR or MEM_WR ever asserted.
REQ-042 kCMP with HALT_REQ pulsed in DECODE -> FLAG_WR=1, REG_WR=0 in WB, then IDLE; INSTR_CNT preloaded to 0xFFFF stays 0xFFFF.
REQ-043 RST_N=0 during a MEM wait -> IDLE next cycle, all outputs 0, INSTR_CNT=0.
